// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default sizes and divide-by-zero quotient for seq_divider32
package div_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;
    localparam logic [WIDTH_DEF-1:0] DBZ_Q = '1;
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step, trial subtract via full-adder chain
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   r,
    input  logic [W-1:0] d,
    input  logic         in_bit,
    output logic [W:0]   r_next,
    output logic         q_bit
);
    logic [W:0]   a, b, t;
    logic [W+1:0] c;
    logic         unused_top;
    assign a          = {r[W-1:0], in_bit};
    assign b          = ~{1'b0, d};
    assign c[0]       = 1'b1;
    assign unused_top = r[W] ^ c[W+1];
    for (genvar i = 0; i <= W; i++) begin : g_fa
        assign t[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign q_bit  = ~t[W];
    assign r_next = q_bit ? t : a;
endmodule

// File: rtl/seq_divider32.sv
// seq_divider32: iterative restoring divider, one quotient bit per clock
// SIGNED_DIV_EN builds two's-complement support; otherwise is_signed is ignored
module seq_divider32
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r, r_next;
    logic [WIDTH-1:0] qd, d, dvd_abs, dvs_abs, q_fix, r_fix;
    logic             q_bit, neg_q, neg_r, dvd_neg, dvs_neg, accept, dbz, last;

    assign accept = start && (state == IDLE || state == DONE);
    assign dbz    = divisor == '0;
    assign last   = cnt == CNT_W'(WIDTH - 1);

`ifdef SIGNED_DIV_EN
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_abs = dvd_neg ? -dividend : dividend;
    assign dvs_abs = dvs_neg ? -divisor : divisor;
    assign q_fix   = neg_q ? -qd : qd;
    assign r_fix   = neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
`else
    logic unused_sign;
    assign dvd_neg     = 1'b0;
    assign dvs_neg     = 1'b0;
    assign dvd_abs     = dividend;
    assign dvs_abs     = divisor;
    assign q_fix       = qd;
    assign r_fix       = r[WIDTH-1:0];
    assign unused_sign = is_signed ^ neg_q ^ neg_r;
`endif

    div_step #(.W(WIDTH)) u_step (
        .r      (r),
        .d      (d),
        .in_bit (qd[WIDTH-1]),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = accept ? (dbz ? DONE : ITER) :
                     state == ITER ? (last ? FIX : ITER) :
                     state == FIX  ? DONE :
                     state == DONE ? IDLE : state;
        busy       = state == ITER || state == FIX;
        done       = state == DONE;
    end

    // qd starts as |dividend| and is shifted out MSB-first while quotient bits shift in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            r           <= '0;
            qd          <= '0;
            d           <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            r     <= '0;
            qd    <= dvd_abs;
            d     <= dvs_abs;
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
            if (dbz) begin
                quotient    <= {WIDTH{DBZ_Q[0]}};
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == ITER) begin
            cnt <= cnt + 1'b1;
            r   <= r_next;
            qd  <= {qd[WIDTH-2:0], q_bit};
        end else if (state == FIX) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: table-driven scoreboard bench for seq_divider32
module tb_seq_divider32;
`ifdef SIGNED_DIV_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic        sgn;
        logic [31:0] a, b;
        logic [31:0] sq, sr;
        logic [31:0] uq, ur;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] q, r;
        logic        dbz;
        int          lat;
    } ex_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0;
    logic [31:0] dividend = '0, divisor = '0, quotient, remainder;
    logic        busy, done, div_by_zero;
    int          n_checks = 0, n_fail = 0;
    ex_t         sb[$];

    seq_divider32 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input ex_t e, input bit push);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat counts edges with the accept edge as 1; returns at the sample where done is seen
    task automatic wait_done(input int inj_at, output int lat, output int busy_n);
        ex_t e;
        lat = 1;
        busy_n = 0;
        while (!done && lat < 100) begin
            busy_n += int'(busy);
            if (lat == inj_at) begin
                start = 1'b1; is_signed = 1'b1; dividend = 32'd77; divisor = 32'd0;
            end else start = 1'b0;
            @(posedge clk);
            #1 lat++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 32'(lat), 32'd0);
        else if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            chk("latency", 32'(lat), 32'(e.lat));
        end
    endtask

    initial begin
        vec_t tbl[11];
        ex_t  e;
        int   lat, busy_n, done_n;
        tbl[0]  = '{0, 32'd100,        32'd7,        32'd14,       32'd2,        32'd14,       32'd2,        0};
        tbl[1]  = '{1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'd1,        0};
        tbl[2]  = '{1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        32'd0,        32'd7,        0};
        tbl[3]  = '{0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 32'd5,        1};
        tbl[4]  = '{1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        32'd0,        32'h80000000, 0};
        tbl[5]  = '{0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'd0,        0};
        tbl[6]  = '{1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 32'd0,        32'hFFFFFF9C, 0};
        tbl[7]  = '{0, 32'd3,          32'd10,       32'd0,        32'd3,        32'd0,        32'd3,        0};
        tbl[8]  = '{1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFF9, 1};
        tbl[9]  = '{0, 32'h12345678,   32'h1000,     32'h12345,    32'h678,      32'h12345,    32'h678,      0};
        tbl[10] = '{1, 32'd100,        32'd7,        32'd14,       32'd2,        32'd14,       32'd2,        0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            e.q   = (tbl[i].sgn && SIGNED_EN) ? tbl[i].sq : tbl[i].uq;
            e.r   = (tbl[i].sgn && SIGNED_EN) ? tbl[i].sr : tbl[i].ur;
            e.dbz = tbl[i].dbz;
            e.lat = tbl[i].dbz ? 1 : 34;
            drive(tbl[i].sgn, tbl[i].a, tbl[i].b, e, 1'b1);
            wait_done(-1, lat, busy_n);
            chk("busy_cycles", 32'(busy_n), tbl[i].dbz ? 32'd0 : 32'd33);
            @(posedge clk);
            #1 chk("done_pulse", 32'(done), 32'd0);
        end

        e = '{32'd111, 32'd1, 1'b0, 34};
        drive(1'b0, 32'd1000, 32'd9, e, 1'b1);
        wait_done(10, lat, busy_n);
        @(posedge clk);
        #1 chk("midstart_idle", 32'(busy), 32'd0);

        e = '{32'd33, 32'd2, 1'b0, 34};
        drive(1'b0, 32'd200, 32'd6, e, 1'b1);
        wait_done(-1, lat, busy_n);
        e = '{32'd123, 32'd4, 1'b0, 34};
        drive(1'b0, 32'd1234, 32'd10, e, 1'b1);
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(-1, lat, busy_n);

        e = '{32'd0, 32'd0, 1'b0, 0};
        drive(1'b0, 32'd5000, 32'd3, e, 1'b0);
        repeat (13) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_q", quotient, 32'd0);
        chk("arst_r", remainder, 32'd0);
        chk("arst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk) reset = 1'b0;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 done_n += int'(done);
        end
        chk("arst_no_done", 32'(done_n), 32'd0);
        e = '{32'd3, 32'd0, 1'b0, 34};
        drive(1'b0, 32'd9, 32'd3, e, 1'b1);
        wait_done(-1, lat, busy_n);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
